tick_scheduler: RTL

- Rate controller that sits between clock_divider's divided_clocks bus and the FSMs on the board.
- Selects one divider tap and converts its rising edges into single-cycle tick enables in the CLOCK_50 domain, so FSMs run on clk with an enable instead of on a divided clock.
- Supports run/pause/single-step and runtime rate changes through a valid/ready handshake.
- Rate changes apply only at a period boundary, so the tick period never glitches.

---
 rtl/tick_scheduler.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/tick_scheduler.sv
// -----------------------------------------------------------------------------
// tick_scheduler
//
// Rate controller between the clock_divider's divided_clocks bus and the
// board FSMs. One divider tap is selected; each rising edge of that tap is
// turned into a single-cycle 'tick' enable in the clk (CLOCK_50) domain so the
// FSMs can run on clk with an enable instead of on a divided clock.
//
// Supports run / pause / single-step, and runtime rate changes through a
// valid/ready request. A new rate only takes effect on a rising edge of the
// old tap, so the tick period never glitches mid-period.
//
// Parameters:
//   TAPS       width of divided_clocks (taps 0..TAPS-1)
//   RESET_SEL  tap selected after reset
//   MAX_SEL    highest legal tap; larger requests are clamped to MAX_SEL
//
// Ports:
//   clk             in   system clock (CLOCK_50)
//   reset           in   synchronous, active-high reset
//   divided_clocks  in   free-running divider bus [TAPS-1:0]
//   sel_valid       in   rate-change request
//   sel_idx         in   requested tap index [4:0]
//   sel_ready       out  request can be accepted this cycle
//   sel_ack         out  one-cycle pulse when the new rate is in effect
//   pause           in   level, 1 = hold ticks
//   step            in   one-cycle pulse, emit one tick while paused
//   tick            out  one-cycle enable per rising edge of the active tap
//   cur_sel         out  active tap index [4:0]
//   mode            out  encoded state: RUN=0, PAUSED=1, STEP=2, SWITCH=3
//   tick_count      out  (only with TICK_SCHEDULER_COUNT_EN) ticks since
//                        reset or since the last sel_ack, wraps at 16 bits
//
// Handshake: a rate request transfers on a clk edge where sel_valid and
// sel_ready are both high. sel_ready is high only in RUN or PAUSED and is low
// while reset is asserted. sel_valid may be held; once transferred, the
// requester sees sel_ready drop until the switch completes, and sel_ack marks
// the first cycle in which cur_sel shows the new tap.
//
// Optional feature macro: TICK_SCHEDULER_COUNT_EN (adds tick_count).
// -----------------------------------------------------------------------------
module tick_scheduler #(
    parameter int unsigned TAPS      = 32,
    parameter int unsigned RESET_SEL = 25,
    parameter int unsigned MAX_SEL   = 31
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [TAPS-1:0] divided_clocks,
    input  logic            sel_valid,
    input  logic [4:0]      sel_idx,
    output logic            sel_ready,
    output logic            sel_ack,
    input  logic            pause,
    input  logic            step,
    output logic            tick,
    output logic [4:0]      cur_sel,
`ifdef TICK_SCHEDULER_COUNT_EN
    output logic [15:0]     tick_count,
`endif
    output logic [1:0]      mode
);

    localparam logic [4:0] RESET_SEL_L = 5'(RESET_SEL);
    localparam logic [4:0] MAX_SEL_L   = 5'(MAX_SEL);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_STEP   = 2'd2,
        ST_SWITCH = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t     state_q,    state_d;
    logic [4:0] cur_sel_q,  cur_sel_d;
    logic       prev_tap_q, prev_tap_d;
    logic       tick_q,     tick_d;
    logic       sel_ack_q,  sel_ack_d;
    logic [4:0] pending_q,  pending_d;   // tap to install at the switch edge
    logic       ret_run_q,  ret_run_d;   // request came from RUN (tick on switch edge)

    // ------------------------------------------------------------------
    // Edge detect on the active tap
    // ------------------------------------------------------------------
    logic       tap;
    logic       rise;
    logic       accept;
    logic       emit;
    logic [4:0] req_clamped;

    assign tap         = divided_clocks[cur_sel_q];
    assign rise        = tap & ~prev_tap_q;
    assign sel_ready   = ~reset & ((state_q == ST_RUN) | (state_q == ST_PAUSED));
    assign accept      = sel_valid & sel_ready;
    assign req_clamped = (sel_idx > MAX_SEL_L) ? MAX_SEL_L : sel_idx;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        prev_tap_d = tap;
        pending_d  = pending_q;
        ret_run_d  = ret_run_q;
        sel_ack_d  = 1'b0;
        emit       = 1'b0;

        case (state_q)
            ST_RUN: begin
                emit = rise;
                if (accept) begin
                    // A pause raised alongside the request is picked up when
                    // SWITCH exits, since the exit re-reads pause.
                    pending_d = req_clamped;
                    ret_run_d = 1'b1;
                    state_d   = ST_SWITCH;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end
            end

            ST_PAUSED: begin
                // Select beats step, step beats un-pause.
                if (accept) begin
                    pending_d = req_clamped;
                    ret_run_d = 1'b0;
                    state_d   = ST_SWITCH;
                end else if (step) begin
                    state_d = ST_STEP;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end

            ST_STEP: begin
                // Further step pulses are ignored here; nothing is queued.
                if (rise) begin
                    emit    = 1'b1;
                    state_d = pause ? ST_PAUSED : ST_RUN;
                end
            end

            ST_SWITCH: begin
                if (rise) begin
                    emit       = ret_run_q;
                    cur_sel_d  = pending_q;
                    // Seed the edge detector with the new tap's current level
                    // so the swap itself never looks like a rising edge.
                    prev_tap_d = divided_clocks[pending_q];
                    sel_ack_d  = 1'b1;
                    state_d    = pause ? ST_PAUSED : ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // A fast new tap can rise in the cycle right after the switch edge;
        // masking against the tick already in flight keeps ticks at least
        // two cycles apart.
        tick_d = emit & ~tick_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            cur_sel_q  <= RESET_SEL_L;
            prev_tap_q <= divided_clocks[RESET_SEL_L];
            tick_q     <= 1'b0;
            sel_ack_q  <= 1'b0;
            pending_q  <= RESET_SEL_L;
            ret_run_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cur_sel_q  <= cur_sel_d;
            prev_tap_q <= prev_tap_d;
            tick_q     <= tick_d;
            sel_ack_q  <= sel_ack_d;
            pending_q  <= pending_d;
            ret_run_q  <= ret_run_d;
        end
    end

    assign tick    = tick_q;
    assign sel_ack = sel_ack_q;
    assign cur_sel = cur_sel_q;
    assign mode    = state_q;

`ifdef TICK_SCHEDULER_COUNT_EN
    // ------------------------------------------------------------------
    // Tick counter: restarts at zero when a new rate is acknowledged.
    // The clear lands together with sel_ack, so the count shown alongside
    // sel_ack is already zero.
    // ------------------------------------------------------------------
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (sel_ack_d) begin
            count_d = 16'd0;
        end else if (tick_q) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_count = count_q;
`endif

endmodule
